// File: rtl/uart_receiver.sv
// UART receiver: synchronized serial input, start/data/stop framing with oversampled bit timing,
// a valid/ready output holding register, and one-cycle framing and overrun pulses.
module uart_receiver #(
   parameter int DATA_SIZE    = 8,
   parameter int CLKS_PER_BIT = 1,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 serial_data_in,
   input  logic                 rx_ready,
   output logic [DATA_SIZE-1:0] data_out,
   output logic                 rx_valid,
   output logic                 framing_error,
   output logic                 overrun_error
);

   localparam int unsigned HALF       = (CLKS_PER_BIT - 1) / 2;
   localparam int unsigned START_LAST = (HALF > 0) ? HALF - 1 : 0;
   localparam int          BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int          BIT_W      = $clog2(DATA_SIZE + 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [BAUD_W-1:0]      r_baud;
   logic [BIT_W-1:0]       r_bit;
   logic [DATA_SIZE-1:0]   r_shift;
   logic [DATA_SIZE-1:0]   r_data;
   logic                   r_valid;
   logic                   r_framing;
   logic                   r_overrun;

   logic                   w_rx;
   logic                   w_baud_done;
   logic                   w_start_done;
   logic                   w_bit_last;
   logic                   w_transition;
   logic                   w_shift;
   logic                   w_stop_good;
   logic                   w_stop_bad;
   logic [DATA_SIZE:0]     w_cat;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_sync <= '1;
      else          r_sync <= {r_sync[SYNC_STAGES-2:0], serial_data_in};
   end

   assign w_rx         = r_sync[SYNC_STAGES-1];
   assign w_baud_done  = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
   assign w_start_done = (r_baud == BAUD_W'(START_LAST));
   assign w_bit_last   = (r_bit == BIT_W'(DATA_SIZE - 1));
   assign w_cat        = {w_rx, r_shift};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   // With no half-bit delay the start bit is its own sample, so IDLE skips START.
   always_comb begin
      w_state_next = r_state;
      w_shift      = 1'b0;
      w_stop_good  = 1'b0;
      w_stop_bad   = 1'b0;
      case (r_state)
         IDLE:  if (!w_rx) w_state_next = (HALF == 0) ? DATA : START;
         START: if (w_start_done) w_state_next = w_rx ? IDLE : DATA;
         DATA: begin
            if (w_baud_done) begin
               w_shift = 1'b1;
               if (w_bit_last) w_state_next = STOP;
            end
         end
         STOP: begin
            if (w_baud_done) begin
               if (w_rx) begin
                  w_stop_good  = 1'b1;
                  w_state_next = IDLE;
               end else begin
                  w_stop_bad   = 1'b1;
                  w_state_next = BREAK;
               end
            end
         end
         BREAK:   if (w_rx) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
      w_transition = (w_state_next != r_state);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_baud <= '0;
         r_bit  <= '0;
      end else begin
         if (w_transition || w_shift)
            r_baud <= '0;
         else if (r_state == START || r_state == DATA || r_state == STOP)
            r_baud <= r_baud + BAUD_W'(1);
         if (w_transition)
            r_bit <= '0;
         else if (w_shift)
            r_bit <= r_bit + BIT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shift   <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_framing <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_framing <= w_stop_bad;
         r_overrun <= w_stop_good && r_valid && !rx_ready;
         if (w_shift) r_shift <= w_cat[DATA_SIZE:1];
         // A byte consumed on the same edge a new one lands leaves rx_valid high.
         if (w_stop_good && (!r_valid || rx_ready)) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign data_out      = r_data;
   assign rx_valid      = r_valid;
   assign framing_error = r_framing;
   assign overrun_error = r_overrun;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: one instance at defaults, one at CLKS_PER_BIT=16,
// driven by a frame-level transmitter model with expected bytes and arrival cycles queued.
module tb_uart_receiver;

   localparam int LAT0  = 2 + 1 + 0 + 9 * 1;
   localparam int LAT16 = 2 + 1 + 7 + 9 * 16;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b1;
   logic       ser0    = 1'b1;
   logic       ser1    = 1'b1;
   logic       rdy0    = 1'b1;
   logic       rdy1    = 1'b1;
   logic [7:0] dout0, dout1;
   logic       val0, val1, fe0, fe1, ov0, ov1;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] data;
      int         cyc;
      bit         tchk;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   exp_fe0 = 0, act_fe0 = 0, exp_ov0 = 0, act_ov0 = 0, last_ov0 = -1;
   int   exp_fe1 = 0, act_fe1 = 0, exp_ov1 = 0, act_ov1 = 0;
   int   app0 = 0, app1 = 0;

   uart_receiver dut (
      .clk(clk), .reset_n(reset_n), .serial_data_in(ser0), .rx_ready(rdy0),
      .data_out(dout0), .rx_valid(val0), .framing_error(fe0), .overrun_error(ov0)
   );

   uart_receiver #(.DATA_SIZE(8), .CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut16 (
      .clk(clk), .reset_n(reset_n), .serial_data_in(ser1), .rx_ready(rdy1),
      .data_out(dout1), .rx_valid(val1), .framing_error(fe1), .overrun_error(ov1)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Monitor for the default instance.
   initial begin
      bit   pv = 1'b0, ph = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (val0 && (!pv || ph)) app0 = cyc;
         if (fe0) act_fe0++;
         if (ov0) begin
            act_ov0++;
            last_ov0 = cyc;
         end
         if (val0 && rdy0) begin
            if (q0.size() == 0) begin
               check("dut0_unexpected_byte", int'(dout0), -1);
            end else begin
               e = q0.pop_front();
               check("dut0_data", int'(dout0), int'(e.data));
               if (e.tchk) check("dut0_arrival_cycle", app0, e.cyc);
            end
         end
         pv = val0;
         ph = val0 && rdy0;
      end
   end

   // Monitor for the CLKS_PER_BIT=16 instance.
   initial begin
      bit   pv = 1'b0, ph = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (val1 && (!pv || ph)) app1 = cyc;
         if (fe1) act_fe1++;
         if (ov1) act_ov1++;
         if (val1 && rdy1) begin
            if (q1.size() == 0) begin
               check("dut16_unexpected_byte", int'(dout1), -1);
            end else begin
               e = q1.pop_front();
               check("dut16_data", int'(dout1), int'(e.data));
               if (e.tchk) check("dut16_arrival_cycle", app1, e.cyc);
            end
         end
         pv = val1;
         ph = val1 && rdy1;
      end
   end

   task automatic idle(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input int sel, input logic v, input int n);
      if (sel != 0) ser1 = v;
      else          ser0 = v;
      idle(n);
   endtask

   // Transmitter model: start bit, 8 data bits LSB first, one stop bit.
   task automatic send(input int sel, input logic [7:0] b, input bit push, input bit tchk);
      int   cpb;
      exp_t e;
      cpb = (sel != 0) ? 16 : 1;
      if (push) begin
         e.data = b;
         e.cyc  = cyc + ((sel != 0) ? LAT16 : LAT0);
         e.tchk = tchk;
         if (sel != 0) q1.push_back(e);
         else          q0.push_back(e);
      end
      drive(sel, 1'b0, cpb);
      for (int i = 0; i < 8; i++) drive(sel, b[i], cpb);
      drive(sel, 1'b1, cpb);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog_timeout actual=%0d required=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int ovc;
      logic [7:0] b;

      #1 reset_n = 1'b0;
      idle(3);
      check("reset_data_out", int'(dout0), 0);
      check("reset_rx_valid", int'(val0), 0);
      check("reset_framing", int'(fe0), 0);
      check("reset_overrun", int'(ov0), 0);
      check("reset_dut16_valid", int'(val1), 0);
      reset_n = 1'b1;
      idle(4);

      send(0, 8'hA5, 1'b1, 1'b1);
      idle(4);

      send(0, 8'h00, 1'b1, 1'b1);
      idle(1);
      send(0, 8'hFF, 1'b1, 1'b1);
      idle(1);
      send(0, 8'h3C, 1'b1, 1'b1);
      idle(15);

      // Consumer stalled: second frame must be dropped with one overrun pulse.
      rdy0 = 1'b0;
      send(0, 8'h12, 1'b1, 1'b1);
      idle(1);
      ovc = cyc + LAT0;
      exp_ov0++;
      send(0, 8'h34, 1'b0, 1'b0);
      idle(15);
      check("overrun_hold_data", int'(dout0), 8'h12);
      check("overrun_hold_valid", int'(val0), 1);
      check("overrun_count", act_ov0, exp_ov0);
      check("overrun_cycle", last_ov0, ovc);
      rdy0 = 1'b1;
      idle(4);

      ser0 = 1'b0;
      idle(20);
      ser0 = 1'b1;
      exp_fe0++;
      idle(5);
      check("break_framing_count", act_fe0, exp_fe0);
      check("break_no_valid", int'(val0), 0);
      send(0, 8'h5A, 1'b1, 1'b1);
      idle(15);

      send(1, 8'hC3, 1'b1, 1'b1);
      idle(20);
      ser1 = 1'b0;
      idle(4);
      ser1 = 1'b1;
      idle(60);
      check("glitch_framing", act_fe1, 0);

      // Reset during data bit 4 aborts the frame and the transmitter returns to idle.
      b = 8'h6E;
      drive(0, 1'b0, 1);
      for (int i = 0; i < 4; i++) drive(0, b[i], 1);
      ser0 = b[4];
      #2 reset_n = 1'b0;
      #1;
      check("midreset_data_out", int'(dout0), 0);
      check("midreset_rx_valid", int'(val0), 0);
      check("midreset_framing", int'(fe0), 0);
      check("midreset_overrun", int'(ov0), 0);
      check("midreset_dut16_data", int'(dout1), 0);
      ser0 = 1'b1;
      idle(2);
      reset_n = 1'b1;
      idle(15);
      send(0, 8'h81, 1'b1, 1'b1);
      idle(15);

      for (int n = 0; n < 30; n++) begin
         send(0, 8'($urandom_range(0, 255)), 1'b1, 1'b1);
         idle(int'($urandom_range(0, 2)));
      end
      for (int n = 0; n < 3; n++) begin
         send(1, 8'($urandom_range(0, 255)), 1'b1, 1'b1);
         idle(int'($urandom_range(0, 3)));
      end

      idle(200);
      check("dut0_queue_drained", q0.size(), 0);
      check("dut16_queue_drained", q1.size(), 0);
      check("dut0_framing_total", act_fe0, exp_fe0);
      check("dut0_overrun_total", act_ov0, exp_ov0);
      check("dut16_framing_total", act_fe1, exp_fe1);
      check("dut16_overrun_total", act_ov1, exp_ov1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
